cache_ctrl: RTL and testbench

- Direct-mapped, write-through, no-write-allocate cache controller; sits between the CPU load/store port and the cache bus unit.
- Holds the tag/valid arrays and the line data array.
- Hit reads are served locally.
- Read misses issue a line-refill burst request to the bus unit and capture the returned stream.
- Stores go through to memory as single write-through requests.

---
 rtl/cache_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_cache_ctrl.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate cache controller between the CPU port and the bus unit.
// Optional macro CACHE_BYPASS_EN: addresses with the top bit set bypass the cache.
module cache_ctrl #(
  parameter int BUS_WIDTH  = 8,
  parameter int BUS_ADDR   = 24,
  parameter int LINE_BYTES = 256,
  parameter int LINES      = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          cpu_req,
  input  logic                          cpu_we,
  input  logic [BUS_ADDR-1:0]           cpu_addr,
  input  logic [BUS_WIDTH-1:0]          cpu_wdata,
  output logic [BUS_WIDTH-1:0]          cpu_rdata,
  output logic                          cpu_ready,
  output logic                          cpu_error,
  input  logic                          cache_flush,
  output logic                          read_line_req,
  output logic                          read_req,
  output logic                          write_through_req,
  output logic [BUS_ADDR-1:0]           pa,
  output logic [BUS_WIDTH-1:0]          wt_data,
  input  logic [BUS_WIDTH-1:0]          line_data,
  input  logic [$clog2(LINE_BYTES)-1:0] addr_count,
  input  logic                          line_write,
  input  logic                          trans_rdy,
  input  logic                          bus_error
);
  // state  | meaning
  // IDLE   | waiting for cpu_req or cache_flush
  // LOOKUP | tag compare against the latched address; array data available
  // REFILL | line burst outstanding, capturing line_data beats
  // WTHRU  | single write-through outstanding
  // BYPASS | uncacheable single read outstanding (CACHE_BYPASS_EN only)
  localparam int OFS_W = $clog2(LINE_BYTES);
  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = BUS_ADDR - OFS_W - IDX_W;
  localparam int AW    = OFS_W + IDX_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_REFILL,
    S_WTHRU
`ifdef CACHE_BYPASS_EN
    , S_BYPASS
`endif
  } state_t;

  state_t               state;
  logic                 we_q;
  logic [LINES-1:0]     valid;
  logic [TAG_W-1:0]     tag_arr [LINES];
  logic [BUS_WIDTH-1:0] mem [LINES*LINE_BYTES];
  logic [BUS_WIDTH-1:0] rd_data;

  logic [TAG_W-1:0]     pa_tag;
  logic [IDX_W-1:0]     pa_idx;
  logic                 hit;
  logic [AW-1:0]        rd_addr;
  logic                 mem_we;
  logic [AW-1:0]        mem_waddr;
  logic [BUS_WIDTH-1:0] mem_wdata;

  assign pa_tag  = pa[BUS_ADDR-1 -: TAG_W];
  assign pa_idx  = pa[OFS_W +: IDX_W];
  assign hit     = valid[pa_idx] && (tag_arr[pa_idx] == pa_tag);
  // In IDLE the read is launched from the incoming address so LOOKUP sees data next cycle.
  assign rd_addr = (state == S_IDLE) ? cpu_addr[AW-1:0] : pa[AW-1:0];

  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = pa[AW-1:0];
    mem_wdata = wt_data;
    if (state == S_REFILL && line_write) begin
      mem_we    = 1'b1;
      mem_waddr = {pa_idx, addr_count};
      mem_wdata = line_data;
    end else if (state == S_LOOKUP && we_q && hit) begin
      mem_we    = 1'b1;
    end
  end

  // Data and tag arrays carry no reset; a beat landing on the read address is forwarded.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
    if (mem_we && mem_waddr == rd_addr) rd_data <= mem_wdata;
    else                                rd_data <= mem[rd_addr];
    if (state == S_REFILL && trans_rdy && !bus_error) tag_arr[pa_idx] <= pa_tag;
  end

`ifndef CACHE_BYPASS_EN
  assign read_req = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= S_IDLE;
      we_q              <= 1'b0;
      valid             <= '0;
      cpu_ready         <= 1'b0;
      cpu_error         <= 1'b0;
      cpu_rdata         <= '0;
      read_line_req     <= 1'b0;
      write_through_req <= 1'b0;
      pa                <= '0;
      wt_data           <= '0;
`ifdef CACHE_BYPASS_EN
      read_req          <= 1'b0;
`endif
    end else begin
      cpu_ready <= 1'b0;
      cpu_error <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cache_flush) begin
            valid <= '0;
          end else if (cpu_req && !cpu_ready) begin
            pa      <= cpu_addr;
            wt_data <= cpu_wdata;
            we_q    <= cpu_we;
            state   <= S_LOOKUP;
`ifdef CACHE_BYPASS_EN
            if (cpu_addr[BUS_ADDR-1]) begin
              if (cpu_we) begin
                write_through_req <= 1'b1;
                state             <= S_WTHRU;
              end else begin
                read_req <= 1'b1;
                state    <= S_BYPASS;
              end
            end
`endif
          end
        end
        S_LOOKUP: begin
          if (we_q) begin
            write_through_req <= 1'b1;
            state             <= S_WTHRU;
          end else if (hit) begin
            cpu_rdata <= rd_data;
            cpu_ready <= 1'b1;
            state     <= S_IDLE;
          end else begin
            // Line is being overwritten, so it stays invalid until the burst completes.
            valid[pa_idx] <= 1'b0;
            read_line_req <= 1'b1;
            state         <= S_REFILL;
          end
        end
        S_REFILL: begin
          if (bus_error) begin
            read_line_req <= 1'b0;
            valid[pa_idx] <= 1'b0;
            cpu_ready     <= 1'b1;
            cpu_error     <= 1'b1;
            cpu_rdata     <= '0;
            state         <= S_IDLE;
          end else if (trans_rdy) begin
            read_line_req <= 1'b0;
            valid[pa_idx] <= 1'b1;
            state         <= S_LOOKUP;
          end
        end
        S_WTHRU: begin
          if (bus_error) begin
            write_through_req <= 1'b0;
            cpu_ready         <= 1'b1;
            cpu_error         <= 1'b1;
            cpu_rdata         <= '0;
            state             <= S_IDLE;
          end else if (trans_rdy) begin
            write_through_req <= 1'b0;
            cpu_ready         <= 1'b1;
            state             <= S_IDLE;
          end
        end
`ifdef CACHE_BYPASS_EN
        S_BYPASS: begin
          if (bus_error) begin
            read_req  <= 1'b0;
            cpu_ready <= 1'b1;
            cpu_error <= 1'b1;
            cpu_rdata <= '0;
            state     <= S_IDLE;
          end else if (trans_rdy) begin
            read_req  <= 1'b0;
            cpu_rdata <= line_data;
            cpu_ready <= 1'b1;
            state     <= S_IDLE;
          end
        end
`endif
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cache_ctrl.sv
// Bench for cache_ctrl: a bus-unit model plus a memory/line-presence reference model.
module tb_cache_ctrl;
  localparam int LINE_BYTES = 256;
  localparam int LINES      = 4;

  logic        clk, rst_n, cpu_req, cpu_we, cache_flush;
  logic [23:0] cpu_addr, pa;
  logic [7:0]  cpu_wdata, cpu_rdata, wt_data, line_data, addr_count;
  logic        cpu_ready, cpu_error, read_line_req, read_req, write_through_req;
  logic        line_write, trans_rdy, bus_error;

  cache_ctrl dut (
    .clk(clk), .rst_n(rst_n), .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .cpu_ready(cpu_ready), .cpu_error(cpu_error), .cache_flush(cache_flush),
    .read_line_req(read_line_req), .read_req(read_req),
    .write_through_req(write_through_req), .pa(pa), .wt_data(wt_data),
    .line_data(line_data), .addr_count(addr_count), .line_write(line_write),
    .trans_rdy(trans_rdy), .bus_error(bus_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Backing memory: untouched bytes read as (low address byte ^ 0x5A).
  logic [7:0]  bmem [int];
  logic        mvalid [LINES];
  logic [13:0] mtag [LINES];

  typedef struct {
    logic [7:0]  rdata;
    logic        err;
    int          lat;
    int          line_rises;
    int          wt_cnt;
    int          rd_cnt;
    logic [23:0] seen_pa;
    logic [7:0]  seen_wd;
    logic        drop_ok;
    logic        ready_after;
  } obs_t;

  function automatic logic [7:0] bmem_rd(input logic [23:0] a);
    if (bmem.exists(int'(a))) return bmem[int'(a)];
    return a[7:0] ^ 8'h5A;
  endfunction

  function automatic logic model_hit(input logic [23:0] a);
    return mvalid[a[9:8]] && (mtag[a[9:8]] == a[23:10]);
  endfunction

  // Issues one CPU access from IDLE and plays the bus unit until cpu_ready.
  // err_beat >= 0 makes the bus fail (after that many refill beats for a burst).
  task automatic access(input logic we, input logic [23:0] addr, input logic [7:0] wd,
                        input int err_beat, output obs_t o);
    int   beat, wait_cnt;
    logic prev_line, ended;
    o = '{8'h00, 1'b0, -1, 0, 0, 0, 24'h0, 8'h00, 1'b1, 1'b0};
    beat = 0; wait_cnt = -1; prev_line = 1'b0; ended = 1'b0;
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
    for (int cyc = 1; cyc <= 3000; cyc++) begin
      @(negedge clk);
      cpu_req = 1'b0;
      line_write = 1'b0; trans_rdy = 1'b0; bus_error = 1'b0;
      if (ended && (read_line_req || write_through_req || read_req)) o.drop_ok = 1'b0;
      ended = 1'b0;
      if (cpu_ready) begin
        o.rdata = cpu_rdata; o.err = cpu_error; o.lat = cyc;
        break;
      end
      if (read_line_req && !prev_line) o.line_rises++;
      prev_line = read_line_req;
      if (read_line_req) begin
        if (err_beat >= 0 && beat == err_beat) begin
          bus_error = 1'b1; ended = 1'b1;
        end else if (beat == LINE_BYTES) begin
          trans_rdy = 1'b1; ended = 1'b1;
        end else if ($urandom_range(3) != 0) begin
          line_write = 1'b1;
          addr_count = beat[7:0];
          line_data  = bmem_rd({addr[23:8], beat[7:0]});
          beat++;
        end
      end
      if (write_through_req || read_req) begin
        if (wait_cnt == -1) begin
          wait_cnt = $urandom_range(3);
          if (write_through_req) begin
            o.wt_cnt++; o.seen_pa = pa; o.seen_wd = wt_data;
          end else o.rd_cnt++;
        end
        if (wait_cnt == 0) begin
          ended = 1'b1;
          if (err_beat >= 0) bus_error = 1'b1;
          else begin
            trans_rdy = 1'b1;
            if (write_through_req) bmem[int'(addr)] = wd;
            else line_data = bmem_rd(addr);
          end
          wait_cnt = -2;
        end else if (wait_cnt > 0) wait_cnt--;
      end
    end
    @(negedge clk);
    o.ready_after = cpu_ready;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    cache_flush = 1'b0; line_data = '0; addr_count = '0; line_write = 1'b0;
    trans_rdy = 1'b0; bus_error = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({cpu_ready, cpu_error, read_line_req, read_req, write_through_req} !== 5'b0 ||
        pa !== 24'h0 || wt_data !== 8'h0 || cpu_rdata !== 8'h0) begin
      bad++;
      $display("FAIL reset_outputs: got rdy=%b err=%b lreq=%b rreq=%b wreq=%b pa=%h wd=%h rd=%h, want all 0",
               cpu_ready, cpu_error, read_line_req, read_req, write_through_req, pa, wt_data, cpu_rdata);
    end
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < LINES; i++) mvalid[i] = 1'b0;
  endtask

  task automatic test_refill_hit();
    obs_t o;
    access(1'b0, 24'h000105, 8'h00, -1, o);
    total++; if (o.line_rises !== 1) begin bad++; $display("FAIL miss_line_req: got %0d bursts want 1", o.line_rises); end
    total++; if (o.rdata !== 8'h5F || o.err !== 1'b0) begin bad++; $display("FAIL refill_rdata: got %h err=%b want 5f err=0", o.rdata, o.err); end
    total++; if (o.drop_ok !== 1'b1) begin bad++; $display("FAIL refill_req_drop: got %b want 1", o.drop_ok); end
    mvalid[1] = 1'b1; mtag[1] = 14'h0;
    access(1'b0, 24'h000106, 8'h00, -1, o);
    total++; if (o.line_rises !== 0 || o.lat !== 2) begin bad++; $display("FAIL hit_latency: got bursts=%0d lat=%0d want 0 and 2", o.line_rises, o.lat); end
    total++; if (o.rdata !== 8'h5C) begin bad++; $display("FAIL hit_rdata: got %h want 5c", o.rdata); end
    total++; if (o.ready_after !== 1'b0) begin bad++; $display("FAIL ready_pulse: got %b want 0", o.ready_after); end
  endtask

  task automatic test_store();
    obs_t o;
    access(1'b1, 24'h000106, 8'hA5, -1, o);
    total++; if (o.wt_cnt !== 1 || o.line_rises !== 0) begin bad++; $display("FAIL store_hit_reqs: got wt=%0d bursts=%0d want 1 0", o.wt_cnt, o.line_rises); end
    total++; if (o.seen_pa !== 24'h000106 || o.seen_wd !== 8'hA5) begin bad++; $display("FAIL store_pa_data: got %h %h want 000106 a5", o.seen_pa, o.seen_wd); end
    access(1'b0, 24'h000106, 8'h00, -1, o);
    total++; if (o.rdata !== 8'hA5 || o.lat !== 2) begin bad++; $display("FAIL store_then_hit: got %h lat=%0d want a5 lat=2", o.rdata, o.lat); end
    access(1'b1, 24'h000400, 8'h33, -1, o);
    total++; if (o.wt_cnt !== 1 || o.line_rises !== 0 || o.err !== 1'b0) begin bad++; $display("FAIL store_miss: got wt=%0d bursts=%0d err=%b want 1 0 0", o.wt_cnt, o.line_rises, o.err); end
    access(1'b0, 24'h000400, 8'h00, -1, o);
    total++; if (o.line_rises !== 1 || o.rdata !== 8'h33) begin bad++; $display("FAIL no_allocate: got bursts=%0d rd=%h want 1 33", o.line_rises, o.rdata); end
    mvalid[0] = 1'b1; mtag[0] = 14'h1;
  endtask

  task automatic test_bus_error();
    obs_t o;
    access(1'b0, 24'h000200, 8'h00, 5, o);
    total++; if (o.err !== 1'b1 || o.rdata !== 8'h00 || o.lat < 0) begin bad++; $display("FAIL refill_error: got err=%b rd=%h lat=%0d want 1 00 done", o.err, o.rdata, o.lat); end
    total++; if (o.drop_ok !== 1'b1 || o.ready_after !== 1'b0) begin bad++; $display("FAIL error_drop: got drop=%b rdy_after=%b want 1 0", o.drop_ok, o.ready_after); end
    access(1'b0, 24'h000200, 8'h00, -1, o);
    total++; if (o.line_rises !== 1 || o.rdata !== 8'h5A || o.err !== 1'b0) begin bad++; $display("FAIL reload_after_error: got bursts=%0d rd=%h err=%b want 1 5a 0", o.line_rises, o.rdata, o.err); end
    mvalid[2] = 1'b1; mtag[2] = 14'h0;
    access(1'b1, 24'h0003FF, 8'h77, 0, o);
    total++; if (o.err !== 1'b1 || o.wt_cnt !== 1 || o.drop_ok !== 1'b1) begin bad++; $display("FAIL wthru_error: got err=%b wt=%0d drop=%b want 1 1 1", o.err, o.wt_cnt, o.drop_ok); end
  endtask

  task automatic test_flush();
    obs_t o;
    logic seen;
    seen = 1'b0;
    cache_flush = 1'b1; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 24'h000105;
    @(negedge clk);
    cache_flush = 1'b0; cpu_req = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (cpu_ready || read_line_req || write_through_req) seen = 1'b1;
    end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL flush_priority: got activity=%b want 0", seen); end
    for (int i = 0; i < LINES; i++) mvalid[i] = 1'b0;
    access(1'b0, 24'h000106, 8'h00, -1, o);
    total++; if (o.line_rises !== 1 || o.rdata !== 8'hA5) begin bad++; $display("FAIL flush_refill: got bursts=%0d rd=%h want 1 a5", o.line_rises, o.rdata); end
    mvalid[1] = 1'b1; mtag[1] = 14'h0;
  endtask

  task automatic test_reset_mid_burst();
    obs_t o;
    int   beat;
    beat = 0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 24'h000300;
    repeat (20) begin
      @(negedge clk);
      cpu_req = 1'b0; line_write = 1'b0;
      if (read_line_req) begin
        line_write = 1'b1; addr_count = beat[7:0];
        line_data = bmem_rd({16'h0003, beat[7:0]}); beat++;
      end
    end
    total++; if (read_line_req !== 1'b1) begin bad++; $display("FAIL burst_started: got %b want 1", read_line_req); end
    line_write = 1'b0; rst_n = 1'b0;
    #1;
    total++; if (read_line_req !== 1'b0 || cpu_ready !== 1'b0) begin bad++; $display("FAIL async_reset_drop: got lreq=%b rdy=%b want 0 0", read_line_req, cpu_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < LINES; i++) mvalid[i] = 1'b0;
    access(1'b0, 24'h000105, 8'h00, -1, o);
    total++; if (o.line_rises !== 1 || o.rdata !== 8'h5F) begin bad++; $display("FAIL valid_cleared_by_reset: got bursts=%0d rd=%h want 1 5f", o.line_rises, o.rdata); end
    mvalid[1] = 1'b1; mtag[1] = 14'h0;
  endtask

  task automatic test_random();
    obs_t        o;
    logic [23:0] a;
    logic [7:0]  wd;
    logic        we, exp_hit;
    int          eb;
    for (int n = 0; n < 40; n++) begin
      a  = {12'h0, 2'($urandom_range(2)), 2'($urandom_range(3)), 8'($urandom)};
      we = ($urandom_range(9) < 3);
      wd = 8'($urandom);
      eb = (!we && $urandom_range(9) == 0) ? int'($urandom_range(250)) : -1;
      exp_hit = model_hit(a);
      access(we, a, wd, eb, o);
      total++;
      if (o.lat < 0) begin bad++; $display("FAIL rnd_timeout: addr=%h got no ready", a); end
      else if (we) begin
        total++;
        if (o.wt_cnt !== 1 || o.line_rises !== 0 || o.seen_pa !== a || o.seen_wd !== wd || o.err !== 1'b0) begin
          bad++; $display("FAIL rnd_store: addr=%h got wt=%0d bursts=%0d pa=%h wd=%h err=%b want 1 0 %h %h 0",
                          a, o.wt_cnt, o.line_rises, o.seen_pa, o.seen_wd, o.err, a, wd);
        end
      end else if (exp_hit) begin
        total++;
        if (o.line_rises !== 0 || o.lat !== 2 || o.rdata !== bmem_rd(a)) begin
          bad++; $display("FAIL rnd_hit: addr=%h got bursts=%0d lat=%0d rd=%h want 0 2 %h", a, o.line_rises, o.lat, o.rdata, bmem_rd(a));
        end
      end else if (eb >= 0) begin
        total++;
        if (o.line_rises !== 1 || o.err !== 1'b1 || o.rdata !== 8'h00) begin
          bad++; $display("FAIL rnd_miss_err: addr=%h got bursts=%0d err=%b rd=%h want 1 1 00", a, o.line_rises, o.err, o.rdata);
        end
        mvalid[a[9:8]] = 1'b0;
      end else begin
        total++;
        if (o.line_rises !== 1 || o.err !== 1'b0 || o.rdata !== bmem_rd(a)) begin
          bad++; $display("FAIL rnd_miss: addr=%h got bursts=%0d err=%b rd=%h want 1 0 %h", a, o.line_rises, o.err, o.rdata, bmem_rd(a));
        end
        mvalid[a[9:8]] = 1'b1; mtag[a[9:8]] = a[23:10];
      end
    end
  endtask

`ifdef CACHE_BYPASS_EN
  task automatic test_bypass();
    obs_t o;
    access(1'b0, 24'h800010, 8'h00, -1, o);
    total++; if (o.rd_cnt !== 1 || o.line_rises !== 0 || o.rdata !== 8'h4A) begin bad++; $display("FAIL bypass_load: got rd=%0d bursts=%0d data=%h want 1 0 4a", o.rd_cnt, o.line_rises, o.rdata); end
    access(1'b1, 24'h800105, 8'hC3, -1, o);
    total++; if (o.wt_cnt !== 1 || o.line_rises !== 0 || o.rd_cnt !== 0) begin bad++; $display("FAIL bypass_store: got wt=%0d bursts=%0d rd=%0d want 1 0 0", o.wt_cnt, o.line_rises, o.rd_cnt); end
    access(1'b0, 24'h000105, 8'h00, -1, o);
    total++; if (o.lat !== 2 || o.rdata !== bmem_rd(24'h000105)) begin bad++; $display("FAIL bypass_array_intact: got lat=%0d rd=%h want 2 %h", o.lat, o.rdata, bmem_rd(24'h000105)); end
  endtask
`endif

  initial begin
    test_reset();
    test_refill_hit();
    test_store();
    test_bus_error();
    test_flush();
    test_reset_mid_burst();
`ifdef CACHE_BYPASS_EN
    test_bypass();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
